// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if: operand/result bundle for the chunked adder/subtractor.
//   Request side : in_valid, in_ready, a, b, sub, carryin
//   Result side  : out_valid, out_ready, sum, carryout, overflow, zero
// The slave modport is the adder's view; master is the producer/consumer view.
interface chunked_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carryin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, sub, carryin, out_ready,
    output in_ready, out_valid, sum, carryout, overflow, zero
  );

  modport master (
    output in_valid, a, b, sub, carryin, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow, zero
  );
endinterface

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor, CHUNK bits per clock, LS chunk first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - chunked_addsub_if.slave (request handshake, operands, result handshake, flags)
// Subtract is done as a + ~b + (1 - carryin); carryout = 1 means "no borrow" in sub mode.
// The interface WIDTH must match this module's WIDTH.
module chunked_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic           clk,
  input logic           rst_n,
  chunked_addsub_if.slave bus
);
  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // already inverted for subtract
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             zero_q, zero_d;

  logic [BW-1:0]    base;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             cin_msb;
  logic             accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      k_q    <= '0;
      c_q    <= 1'b0;
      co_q   <= 1'b0;
      ov_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      k_q    <= k_d;
      c_q    <= c_d;
      co_q   <= co_d;
      ov_q   <= ov_d;
      zero_q <= zero_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Chunk adder and datapath next-state
  always_comb begin
    accept     = (state_q == StIdle) && bus.in_valid;
    last_chunk = (k_q == KLast);
    base       = BW'(32'(k_q) * CHUNK);
    chunk_sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
               + (CHUNK + 1)'(c_q);

    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    sum_d  = sum_q;
    k_d    = k_q;
    c_d    = c_q;
    co_d   = co_q;
    ov_d   = ov_q;
    zero_d = zero_q;

    acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Sum bit = a ^ b' ^ carry-in, so the carry into the MSB falls out of the final sum bit.
    cin_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_d[WIDTH-1];

    if (accept) begin
      a_d = bus.a;
      b_d = bus.sub ? ~bus.b : bus.b;
      c_d = bus.carryin ^ bus.sub;
      k_d = '0;
    end else if (state_q == StRun) begin
      c_d = chunk_sum[CHUNK];
      k_d = k_q + KW'(1);
      if (last_chunk) begin
        k_d    = '0;
        sum_d  = acc_d;
        co_d   = chunk_sum[CHUNK];
        ov_d   = cin_msb ^ chunk_sum[CHUNK];
        zero_d = (acc_d == '0);
      end
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.sum       = sum_q;
    bus.carryout  = co_q;
    bus.overflow  = ov_q;
    bus.zero      = zero_q;
  end
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three instances (CHUNK = 8, 1, 32) sharing operands,
// expected results queued at acceptance and compared on each output handshake.
module tb_chunked_addsub;
  localparam int unsigned W = 32;
  localparam int unsigned ChunkTab [3] = '{8, 1, 32};

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] tb_a, tb_b;
  logic         tb_sub, tb_cin;
  logic         iv   [3];
  logic         ordy [3];

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic [W-1:0] sum_w       [3];
  logic         co_w        [3];
  logic         ov_w        [3];
  logic         z_w         [3];

  exp_t q0[$], q1[$], q2[$];
  int   n_vec = 0;
  int   n_bad = 0;

  chunked_addsub_if #(.WIDTH(W)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].in_valid  = iv[g];
    assign ifs[g].out_ready = ordy[g];
    assign ifs[g].a         = tb_a;
    assign ifs[g].b         = tb_b;
    assign ifs[g].sub       = tb_sub;
    assign ifs[g].carryin   = tb_cin;
    assign in_ready_w[g]    = ifs[g].in_ready;
    assign out_valid_w[g]   = ifs[g].out_valid;
    assign sum_w[g]         = ifs[g].sum;
    assign co_w[g]          = ifs[g].carryout;
    assign ov_w[g]          = ifs[g].overflow;
    assign z_w[g]           = ifs[g].zero;

    chunked_addsub #(
      .WIDTH(W),
      .CHUNK(ChunkTab[g])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifs[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov,
                              input logic z);
    exp_t e;
    e.sum = s;
    e.co  = co;
    e.ov  = ov;
    e.z   = z;
    return e;
  endfunction

  // Reference: (W+1)-bit add of a + b' + c0, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W + 1)'(c ^ s);
    return mk(full[W-1:0], full[W], (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]),
              full[W-1:0] == '0);
  endfunction

  task automatic push(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Scoreboard: compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid_w[i] && ordy[i]) begin
          have = 1'b0;
          case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          if (!have) begin
            check_eq($sformatf("unexpected_out%0d", i), 64'(1), 64'(0));
          end else begin
            check_eq($sformatf("sum%0d", i), 64'(sum_w[i]), 64'(e.sum));
            check_eq($sformatf("carryout%0d", i), 64'(co_w[i]), 64'(e.co));
            check_eq($sformatf("overflow%0d", i), 64'(ov_w[i]), 64'(e.ov));
            check_eq($sformatf("zero%0d", i), 64'(z_w[i]), 64'(e.z));
          end
        end
      end
    end
  end

  // Wait (bounded) for out_valid; lat counts edges with the acceptance edge as 1.
  task automatic wait_done(input int idx, output int lat);
    lat = 1;
    while (!out_valid_w[idx] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Called at posedge+1 with the instance idle; returns at posedge+1 back in IDLE.
  task automatic run_op(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cv, input exp_t e, input int elat);
    int lat;
    tb_a = av; tb_b = bv; tb_sub = sv; tb_cin = cv;
    ordy[idx] = 1'b1;
    check_eq($sformatf("idle_ready%0d", idx), 64'(in_ready_w[idx]), 64'(1));
    push(idx, e);
    iv[idx] = 1'b1;
    @(posedge clk);
    #1;
    iv[idx] = 1'b0;
    tb_a = ~av; tb_b = ~bv; tb_sub = ~sv; tb_cin = ~cv;
    check_eq($sformatf("busy_ready%0d", idx), 64'(in_ready_w[idx]), 64'(0));
    wait_done(idx, lat);
    check_eq($sformatf("latency%0d", idx), 64'(lat), 64'(elat));
    @(posedge clk);
    #1;
    check_eq($sformatf("post_valid%0d", idx), 64'(out_valid_w[idx]), 64'(0));
  endtask

  initial begin
    int       lat;
    logic [W-1:0] ra, rb;
    logic     rs, rc;
    clk = 1'b0; rst_n = 1'b1;
    tb_a = '0; tb_b = '0; tb_sub = 1'b0; tb_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
    #2 rst_n = 1'b0;
    #3;
    check_eq("rst_valid", 64'(out_valid_w[0]), 64'(0));
    check_eq("rst_ready", 64'(in_ready_w[0]), 64'(1));
    check_eq("rst_sum", 64'(sum_w[0]), 64'(0));
    check_eq("rst_flags", {61'd0, co_w[0], ov_w[0], z_w[0]}, 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1), 5);
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, mk(32'h8000_0001, 1'b0, 1'b1, 1'b0), 5);
    run_op(0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0100_0000, 1'b0, 1'b0, 1'b0), 5);
    run_op(0, 32'd5, 32'd7, 1'b1, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), 5);
    run_op(0, 32'h8000_0000, 32'd1, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), 5);
    run_op(0, 32'd5, 32'd5, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), 5);
    run_op(0, 32'd5, 32'd5, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1), 5);
    run_op(0, 32'd0, 32'd0, 1'b0, 1'b1, mk(32'h1, 1'b0, 1'b0, 1'b0), 5);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      run_op(0, ra, rb, rs, rc, model(ra, rb, rs, rc), 5);
    end

    run_op(1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1), 33);
    run_op(2, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1), 2);
    run_op(1, 32'h8000_0000, 32'd1, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), 33);
    run_op(2, 32'h7FFF_FFFF, 32'd2, 1'b0, 1'b0, mk(32'h8000_0001, 1'b0, 1'b1, 1'b0), 2);

    // Backpressure: hold DONE while a new request waits.
    ordy[0] = 1'b0;
    tb_a = 32'h7FFF_FFFF; tb_b = 32'd2; tb_sub = 1'b0; tb_cin = 1'b0;
    push(0, mk(32'h8000_0001, 1'b0, 1'b1, 1'b0));
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    wait_done(0, lat);
    check_eq("bp_latency", 64'(lat), 64'(5));
    tb_a = 32'd3; tb_b = 32'd4;
    iv[0] = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_valid", 64'(out_valid_w[0]), 64'(1));
      check_eq("bp_hold_ready", 64'(in_ready_w[0]), 64'(0));
      check_eq("bp_hold_sum", 64'(sum_w[0]), 64'(32'h8000_0001));
      check_eq("bp_hold_ovf", 64'(ov_w[0]), 64'(1));
    end
    push(0, mk(32'd7, 1'b0, 1'b0, 1'b0));
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_idle_ready", 64'(in_ready_w[0]), 64'(1));
    check_eq("bp_idle_valid", 64'(out_valid_w[0]), 64'(0));
    check_eq("bp_retained_sum", 64'(sum_w[0]), 64'(32'h8000_0001));
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    check_eq("bp_accepted", 64'(in_ready_w[0]), 64'(0));
    wait_done(0, lat);
    check_eq("bp_new_latency", 64'(lat), 64'(5));
    @(posedge clk);
    #1;

    // Reset after E2 of 0x7FFFFFFF + 2: nothing is queued, so any output is unexpected.
    tb_a = 32'h7FFF_FFFF; tb_b = 32'd2; tb_sub = 1'b0; tb_cin = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 64'(out_valid_w[0]), 64'(0));
    check_eq("mr_sum", 64'(sum_w[0]), 64'(0));
    check_eq("mr_flags", {61'd0, co_w[0], ov_w[0], z_w[0]}, 64'(0));
    check_eq("mr_ready", 64'(in_ready_w[0]), 64'(1));
    tb_a = 32'd1; tb_b = 32'd1;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mr_no_accept", 64'(in_ready_w[0]), 64'(1));
    iv[0] = 1'b0;
    rst_n = 1'b1;
    run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, mk(32'd7, 1'b0, 1'b0, 1'b0), 5);

    repeat (2) @(posedge clk);
    #1;
    check_eq("drain", 64'(q0.size() + q1.size() + q2.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
